grant_arbiter: RTL and testbench
================================

GRANT_ARBITER -- requirements
Module: grant_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter GRANT_TIMEOUT, default 16, giving the maximum number of cycles a grant is held before revocation (2..255).
REQ-003 Port i_ck SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port i_arst SHALL be an input, 1 bit wide, carrying an asynchronous, active-high reset.
REQ-005 Port i_req SHALL be an input, N_REQ bits wide; bit n is requester n's level request, held until released.
REQ-006 Port o_gnt SHALL be an output, N_REQ bits wide; it is the one-hot grant to the owning requester.
REQ-007 Port o_revoke SHALL be an output, N_REQ bits wide; it is the one-hot revoke demand to the owning requester.
REQ-008 Port o_grantId SHALL be an output, $clog2(N_REQ) bits wide, holding the index of the current owner; 0 when there is no owner.
REQ-009 Port o_busy SHALL be an output, 1 bit wide, high while in state GRANT or REVOKE.
REQ-010 Port o_revokeCount SHALL be an output, 8 bits wide, counting revocations and saturating at 255.

Function
REQ-011 The state machine SHALL have exactly four states: IDLE, GRANT, REVOKE and RELEASE; all outputs SHALL decode from registered state (Moore).
REQ-012 In IDLE with any i_req bit high at edge t, the block SHALL enter GRANT, with o_gnt one-hot on the winner from cycle t+1 (one-cycle grant latency).
REQ-013 Arbitration SHALL be round-robin: the search starts at index (last owner + 1) mod N_REQ, takes the first set bit, and gives the lowest index priority after reset.
REQ-014 The round-robin pointer SHALL update only on the IDLE->GRANT transition.
REQ-015 In IDLE with i_req all-zero, the block SHALL remain in IDLE.
REQ-016 An owner/cycle timer SHALL clear on GRANT entry and increment every cycle spent in GRANT.
REQ-017 In GRANT, if the owner's i_req bit is low, the block SHALL go to RELEASE, and this SHALL take priority over timeout.
REQ-018 In GRANT, if the owner's i_req bit is high and the timer equals GRANT_TIMEOUT-1, the block SHALL go to REVOKE, so o_gnt is high for exactly GRANT_TIMEOUT cycles before o_revoke rises.
REQ-019 In REVOKE, o_gnt and o_revoke SHALL both be high on the owner's bit, o_revokeCount SHALL increment once on entry, and the block SHALL stay in REVOKE until the owner's i_req bit falls, then go to RELEASE.
REQ-020 RELEASE SHALL last exactly one cycle with o_gnt=0, o_revoke=0 and o_busy=0, then go to IDLE; a released requester therefore cannot be re-granted sooner than 2 cycles after it drops i_req.
REQ-021 Request changes of non-owners SHALL be ignored outside IDLE, with no grant preemption.
REQ-022 Simultaneous requests in IDLE SHALL be resolved by REQ-013 alone.
REQ-023 An unreachable state encoding SHALL transition to IDLE.
REQ-024 o_revokeCount SHALL hold at 255 and never wrap.

Reset
REQ-025 Asserting i_arst SHALL immediately, independent of i_ck, put the block in state IDLE, with timer 0, round-robin pointer = N_REQ-1 (so index 0 wins first), and o_gnt=0, o_revoke=0, o_grantId=0, o_busy=0, o_revokeCount=0.
REQ-026 Reset during GRANT or REVOKE SHALL drop o_gnt and o_revoke in the same cycle, and the first grant after release SHALL follow REQ-012 from the first edge after i_arst deasserts.

Verification
REQ-027 The bench SHALL cover this scenario: reset, then i_req=4'b0100 held 3 cycles then dropped -> o_gnt=4'b0100 one cycle after, o_grantId=2 for 3 cycles, then one RELEASE cycle with all outputs 0, then IDLE.
REQ-028 The bench SHALL cover this scenario: i_req=4'b1111 held continuously with each owner dropping its bit 2 cycles into its grant and reasserting it -> grant order 0,1,2,3,0.
REQ-029 The bench SHALL cover this scenario: GRANT_TIMEOUT=16 and i_req=4'b0001 held -> o_gnt high for 16 cycles, then o_revoke=4'b0001 with o_gnt still high; o_revokeCount=1; dropping i_req gives RELEASE, then IDLE.
REQ-030 The bench SHALL cover this scenario: the owner drops i_req on exactly the cycle the timer reaches 15 -> RELEASE, no REVOKE, and o_revokeCount unchanged.
REQ-031 The bench SHALL cover this scenario: i_arst pulsed mid-REVOKE -> o_gnt=0, o_revoke=0 and o_revokeCount=0 asynchronously, and the next grant goes to the lowest set index.
REQ-032 The bench SHALL cover this scenario: 260 forced revocations -> o_revokeCount saturates at 255.

Source files
------------

// File: rtl/grant_arbiter.sv
// Round-robin grant arbiter with a per-grant hold timer and revoke handshake.
// Owner index doubles as the round-robin pointer; outputs decode from state.
module grant_arbiter #(
  parameter int N_REQ         = 4,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                     i_ck,
  input  logic                     i_arst,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_revoke,
  output logic [$clog2(N_REQ)-1:0] o_grantId,
  output logic                     o_busy,
  output logic [7:0]               o_revokeCount
);

  localparam int W = $clog2(N_REQ);
  localparam logic [7:0] TMAX = 8'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    REVOKE,
    RELEASE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [7:0]     timer_q, timer_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [W-1:0]   win;
  logic [W-1:0]   cand;
  logic           found;
  logic           own_req;
  logic [N_REQ-1:0] own_oh;

  always_ff @(posedge i_ck or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      ptr_q   <= W'(N_REQ - 1);
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  // Search starts just past the last owner and wraps.
  always_comb begin
    win   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = W'((int'(ptr_q) + k) % N_REQ);
      if (!found && i_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign own_req = i_req[ptr_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          ptr_d   = win;
          timer_d = '0;
        end
      end
      GRANT: begin
        timer_d = timer_q + 8'd1;
        if (!own_req) begin
          state_d = RELEASE;
        end else if (timer_q == TMAX) begin
          state_d = REVOKE;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      REVOKE: begin
        if (!own_req) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_oh        = '0;
    own_oh[ptr_q] = 1'b1;
  end

  assign o_busy        = (state_q == GRANT) || (state_q == REVOKE);
  assign o_gnt         = o_busy ? own_oh : '0;
  assign o_revoke      = (state_q == REVOKE) ? own_oh : '0;
  assign o_grantId     = o_busy ? ptr_q : '0;
  assign o_revokeCount = cnt_q;

endmodule

// File: tb/tb_grant_arbiter.sv
// Directed-vector bench for grant_arbiter (N_REQ=4, GRANT_TIMEOUT=16).
// Expected values are hand-derived from the cycle-level behaviour.
module tb_grant_arbiter;

  logic       clk;
  logic       arst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] rvk;
  logic [1:0] gid;
  logic       busy;
  logic [7:0] rcnt;

  int n_chk;
  int n_fail;

  grant_arbiter #(
    .N_REQ(4),
    .GRANT_TIMEOUT(16)
  ) dut (
    .i_ck         (clk),
    .i_arst       (arst),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_revoke     (rvk),
    .o_grantId    (gid),
    .o_busy       (busy),
    .o_revokeCount(rcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #3;
    arst = 1'b0;
    tick();
  endtask

  initial begin
    int e;
    int exp_cnt;
    n_chk  = 0;
    n_fail = 0;
    req    = 4'b0000;
    arst   = 1'b1;
    #2;
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_rvk",  32'(rvk),  32'h0);
    chk("rst_gid",  32'(gid),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt",  32'(rcnt), 32'h0);
    arst = 1'b0;
    tick();
    tick();
    chk("idle_hold", 32'(busy), 32'h0);

    // single requester, held 3 grant cycles
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_gnt",  32'(gnt),  32'h4);
      chk("s1_gid",  32'(gid),  32'h2);
      chk("s1_busy", 32'(busy), 32'h1);
    end
    req = 4'b0000;
    tick();
    chk("s1_rel_gnt",  32'(gnt),  32'h0);
    chk("s1_rel_rvk",  32'(rvk),  32'h0);
    chk("s1_rel_busy", 32'(busy), 32'h0);
    chk("s1_rel_gid",  32'(gid),  32'h0);
    tick();
    chk("s1_idle", 32'(gnt), 32'h0);

    // round robin with all requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      tick();
      chk("rr_gid", 32'(gid), 32'(e));
      chk("rr_gnt", 32'(gnt), 32'(1) << e);
      tick();
      req[e] = 1'b0;
      tick();
      chk("rr_rel", 32'(busy), 32'h0);
      req = 4'b1111;
      tick();
    end
    req = 4'b0000;
    tick();

    // timeout revoke
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_gnt", 32'(gnt), 32'h1);
      chk("to_rvk", 32'(rvk), 32'h0);
      tick();
    end
    chk("to_rvk_on",  32'(rvk),  32'h1);
    chk("to_gnt_on",  32'(gnt),  32'h1);
    chk("to_cnt",     32'(rcnt), 32'h1);
    tick();
    chk("to_rvk_hold", 32'(rvk),  32'h1);
    chk("to_cnt_hold", 32'(rcnt), 32'h1);
    req = 4'b0000;
    tick();
    chk("to_rel_gnt",  32'(gnt),  32'h0);
    chk("to_rel_rvk",  32'(rvk),  32'h0);
    chk("to_rel_busy", 32'(busy), 32'h0);
    tick();
    chk("to_idle", 32'(busy), 32'h0);

    // release on the timer's last cycle beats revoke
    req = 4'b0001;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("edge_gnt", 32'(gnt), 32'h1);
    chk("edge_rvk", 32'(rvk), 32'h0);
    req = 4'b0000;
    tick();
    chk("edge_rel_rvk",  32'(rvk),  32'h0);
    chk("edge_rel_busy", 32'(busy), 32'h0);
    chk("edge_cnt",      32'(rcnt), 32'h1);
    tick();

    // reset in the middle of REVOKE
    req = 4'b0010;
    tick();
    for (int i = 0; i < 16; i++) tick();
    chk("mr_rvk", 32'(rvk),  32'h2);
    chk("mr_cnt", 32'(rcnt), 32'h2);
    req = 4'b0111;
    #2;
    arst = 1'b1;
    #1;
    chk("mr_async_gnt",  32'(gnt),  32'h0);
    chk("mr_async_rvk",  32'(rvk),  32'h0);
    chk("mr_async_cnt",  32'(rcnt), 32'h0);
    chk("mr_async_busy", 32'(busy), 32'h0);
    #1;
    arst = 1'b0;
    req  = 4'b1110;
    tick();
    chk("mr_next_gid", 32'(gid), 32'h1);
    chk("mr_next_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    tick();

    // saturation of the revoke counter
    for (int i = 0; i < 260; i++) begin
      req = 4'b0001;
      tick();
      for (int j = 0; j < 16; j++) tick();
      if (i == 0 || i == 253 || i == 254 || i == 255 || i == 259) begin
        exp_cnt = (i + 1 > 255) ? 255 : i + 1;
        chk("sat_cnt", 32'(rcnt), 32'(exp_cnt));
        chk("sat_rvk", 32'(rvk),  32'h1);
      end
      req = 4'b0000;
      tick();
      tick();
    end
    chk("sat_final", 32'(rcnt), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
